// File: rtl/loader_pkg.sv
// Shared constants for the boot-stream IMEM loader: state encodings,
// length-field size and default IMEM depth.
package loader_pkg;

    localparam int LEN_BYTES       = 2;
    localparam int DEPTH_WORDS_DEF = 256;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEN_LO = 3'd1;
    localparam state_t ST_LEN_HI = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_CSUM   = 3'd4;
    localparam state_t ST_DONE   = 3'd5;
    localparam state_t ST_ERR    = 3'd6;

    // A load must carry at least one word and must fit in the IMEM.
    function automatic logic len_ok(input logic [15:0] n, input int depth);
        return (n != 16'd0) && (int'(n) <= depth);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; word_done is a
// combinational pulse on the byte that completes a word.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  lane;
    logic [31:0] shift_reg;

    assign word_done = byte_valid && (lane == 2'd3);
    // Newest byte enters at the top, so the first byte ends up in [7:0].
    assign word      = {byte_data, shift_reg[31:8]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane      <= 2'd0;
            shift_reg <= 32'd0;
        end else if (clear) begin
            lane      <= 2'd0;
            shift_reg <= 32'd0;
        end else if (byte_valid) begin
            lane      <= lane + 2'd1;
            shift_reg <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-stream loader: receives a length-prefixed, XOR-checksummed byte stream,
// writes it to IMEM word by word and releases the core reset on success.
//
// state   | meaning
// IDLE    | waiting for start, core held in reset
// LEN_LO  | expecting low byte of word count
// LEN_HI  | expecting high byte of word count, then range check
// DATA    | receiving 4*N data bytes
// CSUM    | expecting checksum byte
// DONE    | load good, core released
// ERR     | length or checksum failure, core held in reset
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t      state, state_nxt;
    logic        acc;
    logic        load_req;
    logic [7:0]  len_lo;
    logic [15:0] words_left;
    logic [15:0] word_addr;
    logic [7:0]  csum_xor;
    logic        data_byte;
    logic        word_done;
    logic [31:0] word;

    assign in_ready  = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                       (state == ST_DATA)   || (state == ST_CSUM);
    assign busy      = in_ready;
    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERR);
    assign cpu_rst_n = (state == ST_DONE);

    assign acc       = in_valid && in_ready;
    assign load_req  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign data_byte = acc && (state == ST_DATA);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_req),
        .byte_valid (data_byte),
        .byte_data  (in_data),
        .word_done  (word_done),
        .word       (word)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (load_req) state_nxt = ST_LEN_LO;
            ST_LEN_LO: if (acc) state_nxt = ST_LEN_HI;
            ST_LEN_HI: if (acc) state_nxt = len_ok({in_data, len_lo}, DEPTH_WORDS) ? ST_DATA : ST_ERR;
            ST_DATA:   if (word_done && (words_left == 16'd1)) state_nxt = ST_CSUM;
            ST_CSUM:   if (acc) state_nxt = (in_data == csum_xor) ? ST_DONE : ST_ERR;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // words_left is a down-counter; the word completed at count 1 is the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo     <= 8'd0;
            words_left <= 16'd0;
            word_addr  <= 16'd0;
            csum_xor   <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
        end else begin
            if (load_req) begin
                csum_xor <= 8'd0;
            end
            if (acc && (state == ST_LEN_LO)) begin
                len_lo <= in_data;
            end
            if (acc && (state == ST_LEN_HI)) begin
                words_left <= {in_data, len_lo};
                word_addr  <= 16'd0;
            end
            if (data_byte) begin
                csum_xor <= csum_xor ^ in_data;
            end
            if (word_done) begin
                words_left <= words_left - 16'd1;
                word_addr  <= word_addr + 16'd1;
                imem_addr  <= {14'd0, word_addr, 2'b00};
                imem_wdata <= word;
            end
            imem_we <= word_done;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad loads, length limits,
// back-pressure, reset mid-word and reload from DONE.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader #(.DEPTH_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Stream for two words: 0x00000013 and 0x00100093. XOR of the data bytes is 0x90.
    task automatic send_load(input logic [7:0] csum, input int gap_max, input bit poke_start);
        logic [7:0] s[10];
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 10; i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            if (poke_start && i == 7) begin
                @(negedge clk);
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                chk("bp_busy_after_start", {31'd0, busy}, 32'd1);
            end
            send_byte(s[i]);
        end
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
        send_byte(csum);
    endtask

    task automatic check_two_writes(input string tag);
        chk({tag, "_wr_cnt"}, wr_addr.size(), 32'd2);
        chk({tag, "_addr0"}, wr_addr[0], 32'h0000_0000);
        chk({tag, "_data0"}, wr_data[0], 32'h0000_0013);
        chk({tag, "_addr1"}, wr_addr[1], 32'h0000_0004);
        chk({tag, "_data1"}, wr_data[1], 32'h0010_0093);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("rst_status", {29'd0, busy, done, error}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good load.
        clear_log();
        do_start();
        chk("good_busy", {31'd0, busy}, 32'd1);
        send_load(8'h90, 0, 1'b0);
        chk("good_done", {31'd0, done}, 32'd1);
        chk("good_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        chk("good_err", {31'd0, error}, 32'd0);
        repeat (3) @(negedge clk);
        check_two_writes("good");

        // Reload from DONE.
        clear_log();
        do_start();
        chk("reload_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("reload_done", {31'd0, done}, 32'd0);
        send_load(8'h90, 0, 1'b0);
        chk("reload_done_end", {31'd0, done}, 32'd1);
        chk("reload_cpu_rst_n_end", {31'd0, cpu_rst_n}, 32'd1);
        repeat (3) @(negedge clk);
        check_two_writes("reload");

        // Bad checksum.
        clear_log();
        do_start();
        send_load(8'h81, 0, 1'b0);
        chk("bad_err", {31'd0, error}, 32'd1);
        chk("bad_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("bad_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check_two_writes("bad");

        // Zero length.
        clear_log();
        do_start();
        send_byte(8'h00);
        send_byte(8'h00);
        chk("len0_err", {31'd0, error}, 32'd1);
        chk("len0_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("len0_wr_cnt", wr_addr.size(), 32'd0);

        // 257 words exceeds the 256-word IMEM.
        clear_log();
        do_start();
        send_byte(8'h01);
        send_byte(8'h01);
        chk("len257_err", {31'd0, error}, 32'd1);
        chk("len257_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("len257_wr_cnt", wr_addr.size(), 32'd0);

        // Back-pressure with a stray start during DATA.
        clear_log();
        do_start();
        send_load(8'h90, 2, 1'b1);
        chk("bp_done", {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
        check_two_writes("bp");

        // Reset after the 2nd byte of word 1.
        clear_log();
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h93);
        send_byte(8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_we", {31'd0, imem_we}, 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);
        chk("midrst_wdata", imem_wdata, 32'd0);
        chk("midrst_status", {28'd0, cpu_rst_n, busy, done, error}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_wr_cnt", wr_addr.size(), 32'd1);
        chk("midrst_addr0", wr_addr[0], 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
